// File: rtl/mcdt_nch.sv
// Multi-channel data transfer: NCH valid/ready channels, per-channel FIFOs, round-robin onto one output stream.
// Optional per-channel grant counters on ch_cnt_o when MCDT_STAT_EN is defined.

module mcdt_nch_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int MW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_empty,
    output logic          o_ready,
    output logic [MW-1:0] o_margin
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [MW-1:0] r_count;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data   = r_mem[r_rptr];
    assign o_empty  = (r_count == '0);
    assign o_ready  = (r_count != MW'(DEPTH));
    assign o_margin = MW'(DEPTH) - r_count;
endmodule

module mcdt_nch #(
    parameter int NCH   = 3,
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    localparam int IDW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int MW   = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [NCH*DW-1:0] ch_data_i,
    input  logic [NCH-1:0]    ch_valid_i,
    output logic [NCH-1:0]    ch_ready_o,
    output logic [NCH*MW-1:0] ch_margin_o,
    output logic [DW-1:0]     mcdt_data_o,
    output logic              mcdt_val_o,
    output logic [IDW-1:0]    mcdt_id_o,
    input  logic              mcdt_ready_i
`ifdef MCDT_STAT_EN
    ,
    output logic [NCH*16-1:0] ch_cnt_o
`endif
);
    logic [NCH-1:0][DW-1:0] w_rdata;
    logic [NCH-1:0]         w_empty;
    logic [NCH-1:0]         w_ready;
    logic [NCH-1:0]         w_push;
    logic [NCH-1:0]         w_pop;
    logic                   w_free;
    logic                   w_found;
    logic [IDW-1:0]         w_gnt;
    logic [IDW:0]           w_idx;

    logic                   r_val;
    logic [DW-1:0]          r_data;
    logic [IDW-1:0]         r_id;
    logic [IDW-1:0]         r_last;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign w_push[c] = ch_valid_i[c] & w_ready[c];
        assign w_pop[c]  = w_free & w_found & (w_gnt == IDW'(c));

        mcdt_nch_fifo #(.DW(DW), .DEPTH(DEPTH), .MW(MW)) u_fifo (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .i_push   (w_push[c]),
            .i_data   (ch_data_i[c*DW +: DW]),
            .i_pop    (w_pop[c]),
            .o_data   (w_rdata[c]),
            .o_empty  (w_empty[c]),
            .o_ready  (w_ready[c]),
            .o_margin (ch_margin_o[c*MW +: MW])
        );
    end

    assign ch_ready_o = w_ready;
    assign w_free     = !r_val || mcdt_ready_i;

    // Round-robin: first non-empty channel at or after last+1, wrapping at NCH.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int i = 1; i <= NCH; i++) begin
            w_idx = {1'b0, r_last} + (IDW+1)'(i);
            if (w_idx >= (IDW+1)'(NCH)) w_idx = w_idx - (IDW+1)'(NCH);
            if (!w_found && !w_empty[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_val  <= 1'b0;
            r_data <= '0;
            r_id   <= '0;
            r_last <= IDW'(NCH - 1);
        end else if (w_free) begin
            r_val <= w_found;
            if (w_found) begin
                r_data <= w_rdata[w_gnt];
                r_id   <= w_gnt;
                r_last <= w_gnt;
            end
        end
    end

    assign mcdt_val_o  = r_val;
    assign mcdt_data_o = r_data;
    assign mcdt_id_o   = r_id;

`ifdef MCDT_STAT_EN
    logic [NCH-1:0][15:0] r_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_pop[c]) r_cnt[c] <= r_cnt[c] + 16'd1;
            end
        end
    end

    assign ch_cnt_o = r_cnt;
`endif
endmodule

// File: tb/tb_mcdt_nch.sv
// Directed bench for mcdt_nch (NCH=3, DW=32, DEPTH=32); stats test only when MCDT_STAT_EN is defined.

module tb_mcdt_nch;
    localparam int NCH = 3;
    localparam int DW  = 32;
    localparam int DEP = 32;
    localparam int MW  = 6;
    localparam int IDW = 2;

    logic              clk;
    logic              rstn;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_valid;
    logic [NCH-1:0]    ch_ready;
    logic [NCH*MW-1:0] ch_margin;
    logic [DW-1:0]     mdata;
    logic              mval;
    logic [IDW-1:0]    mid;
    logic              mready;
`ifdef MCDT_STAT_EN
    logic [NCH*16-1:0] ch_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    mcdt_nch #(.NCH(NCH), .DW(DW), .DEPTH(DEP)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .ch_data_i    (ch_data),
        .ch_valid_i   (ch_valid),
        .ch_ready_o   (ch_ready),
        .ch_margin_o  (ch_margin),
        .mcdt_data_o  (mdata),
        .mcdt_val_o   (mval),
        .mcdt_id_o    (mid),
        .mcdt_ready_i (mready)
`ifdef MCDT_STAT_EN
        ,
        .ch_cnt_o     (ch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstn     = 1'b0;
        ch_valid = '0;
        ch_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    function automatic logic [MW-1:0] margin_of(input int c);
        return ch_margin[c*MW +: MW];
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        ch_valid = '0;
        mready = 1'b1;
        #3;
        checks++;
        if (mval !== 1'b0 || mdata !== 32'h0 || mid !== 2'd0) begin
            failures++;
            $display("FAIL reset_out: val=%b data=%h id=%0d, want 0/0/0", mval, mdata, mid);
        end
        checks++;
        if (ch_ready !== 3'b111) begin
            failures++;
            $display("FAIL reset_ready: got %b want 111", ch_ready);
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (margin_of(c) !== 6'd32) begin
                failures++;
                $display("FAIL reset_margin ch%0d: got %0d want 32", c, margin_of(c));
            end
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        mready = 1'b1;
        ch_valid = 3'b001;
        ch_data[31:0] = 32'h00C0_0000;
        tick();
        ch_valid = '0;
        checks++;
        if (mval !== 1'b0 || margin_of(0) !== 6'd31) begin
            failures++;
            $display("FAIL single_k: val=%b margin=%0d want 0/31", mval, margin_of(0));
        end
        tick();
        checks++;
        if (mval !== 1'b1 || mdata !== 32'h00C0_0000 || mid !== 2'd0) begin
            failures++;
            $display("FAIL single_k1: val=%b data=%h id=%0d want 1/00c00000/0", mval, mdata, mid);
        end
        tick();
        checks++;
        if (mval !== 1'b0 || margin_of(0) !== 6'd32) begin
            failures++;
            $display("FAIL single_k2: val=%b margin=%0d want 0/32", mval, margin_of(0));
        end
    endtask

    task automatic test_fill();
        apply_reset();
        mready = 1'b0;
        ch_valid = 3'b010;
        // 33 words accepted: one drains to the output register, 32 fill the FIFO.
        for (int m = 1; m <= 33; m++) begin
            ch_data[63:32] = 32'h00C1_0000 + 32'(m - 1);
            tick();
            checks++;
            if (margin_of(1) !== ((m == 1) ? 6'd31 : 6'(33 - m))) begin
                failures++;
                $display("FAIL fill_margin edge%0d: got %0d want %0d", m, margin_of(1),
                         (m == 1) ? 31 : 33 - m);
            end
        end
        ch_data[63:32] = 32'h00C1_0000 + 32'd33;
        for (int m = 0; m < 32; m++) begin
            tick();
            checks++;
            if (ch_ready[1] !== 1'b0 || margin_of(1) !== 6'd0) begin
                failures++;
                $display("FAIL overflow edge%0d: ready=%b margin=%0d want 0/0", m, ch_ready[1], margin_of(1));
            end
        end
        checks++;
        if (mval !== 1'b1 || mdata !== 32'h00C1_0000 || mid !== 2'd1) begin
            failures++;
            $display("FAIL fill_held: val=%b data=%h id=%0d want 1/00c10000/1", mval, mdata, mid);
        end
        ch_valid = '0;
        mready = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            checks++;
            if (mval !== 1'b1 || mdata !== 32'h00C1_0000 + 32'(e) || mid !== 2'd1
                || margin_of(1) !== 6'(e) || ch_ready[1] !== 1'b1) begin
                failures++;
                $display("FAIL drain word%0d: val=%b data=%h id=%0d margin=%0d rdy=%b want 1/%h/1/%0d/1",
                         e, mval, mdata, mid, margin_of(1), ch_ready[1], 32'h00C1_0000 + 32'(e), e);
            end
        end
        tick();
        checks++;
        if (mval !== 1'b0) begin
            failures++;
            $display("FAIL drain_end: val=%b want 0", mval);
        end
    endtask

    task automatic test_round_robin();
        int n [NCH];
        int e [NCH];
        logic [NCH-1:0] rdy;
        int exp_id;
        logic [31:0] exp_d;
        apply_reset();
        mready = 1'b1;
        ch_valid = 3'b111;
        for (int c = 0; c < NCH; c++) begin
            n[c] = 0;
            e[c] = 0;
        end
        exp_id = 0;
        exp_d  = '0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            for (int c = 0; c < NCH; c++) ch_data[c*DW +: DW] = 32'h00A0_0000 | (32'(c) << 16) | 32'(n[c]);
            rdy = ch_ready;
            tick();
            for (int c = 0; c < NCH; c++) if (rdy[c]) n[c]++;
            if (cyc >= 1) begin
                exp_id = (cyc - 1) % NCH;
                exp_d  = 32'h00A0_0000 | (32'(exp_id) << 16) | 32'(e[exp_id]);
                e[exp_id]++;
                checks++;
                if (mval !== 1'b1 || mid !== 2'(exp_id) || mdata !== exp_d) begin
                    failures++;
                    $display("FAIL rr cyc%0d: val=%b id=%0d data=%h want 1/%0d/%h", cyc, mval, mid, mdata, exp_id, exp_d);
                end
            end
        end
        // Backpressure: output must hold and no FIFO may drain.
        ch_valid = '0;
        mready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            tick();
            checks++;
            if (mval !== 1'b1 || mid !== 2'(exp_id) || mdata !== exp_d) begin
                failures++;
                $display("FAIL bp_hold cyc%0d: val=%b id=%0d data=%h want 1/%0d/%h", b, mval, mid, mdata, exp_id, exp_d);
            end
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (margin_of(c) !== 6'(DEP - (n[c] - e[c]))) begin
                    failures++;
                    $display("FAIL bp_margin ch%0d: got %0d want %0d", c, margin_of(c), DEP - (n[c] - e[c]));
                end
            end
        end
        mready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_id = (exp_id + 1) % NCH;
            exp_d  = 32'h00A0_0000 | (32'(exp_id) << 16) | 32'(e[exp_id]);
            e[exp_id]++;
            checks++;
            if (mval !== 1'b1 || mid !== 2'(exp_id) || mdata !== exp_d) begin
                failures++;
                $display("FAIL bp_resume %0d: val=%b id=%0d data=%h want 1/%0d/%h", k, mval, mid, mdata, exp_id, exp_d);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mready = 1'b0;
        ch_data = {32'h00E2_0000, 32'h00E1_0000, 32'h00E0_0000};
        ch_valid = 3'b111;
        repeat (3) tick();
        ch_valid = 3'b001;
        tick();
        ch_valid = '0;
        // 10 words in flight: one in the output register, 3 in each FIFO.
        checks++;
        if (mval !== 1'b1 || margin_of(0) !== 6'd29 || margin_of(1) !== 6'd29 || margin_of(2) !== 6'd29) begin
            failures++;
            $display("FAIL pre_reset: val=%b margins=%0d/%0d/%0d want 1/29/29/29",
                     mval, margin_of(0), margin_of(1), margin_of(2));
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (mval !== 1'b0 || ch_ready !== 3'b111 || margin_of(0) !== 6'd32
            || margin_of(1) !== 6'd32 || margin_of(2) !== 6'd32) begin
            failures++;
            $display("FAIL mid_reset: val=%b ready=%b margins=%0d/%0d/%0d want 0/111/32/32/32",
                     mval, ch_ready, margin_of(0), margin_of(1), margin_of(2));
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        mready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (mval !== 1'b0) begin
                failures++;
                $display("FAIL post_reset cyc%0d: val=%b data=%h want val 0", k, mval, mdata);
            end
        end
    endtask

`ifdef MCDT_STAT_EN
    task automatic test_stats();
        int n [NCH];
        logic [NCH-1:0] rdy;
        apply_reset();
        mready = 1'b1;
        for (int c = 0; c < NCH; c++) n[c] = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                ch_valid[c] = (n[c] < 100);
                ch_data[c*DW +: DW] = 32'h00B0_0000 | 32'(n[c]);
            end
            rdy = ch_ready & ch_valid;
            tick();
            for (int c = 0; c < NCH; c++) if (rdy[c]) n[c]++;
        end
        ch_valid = '0;
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (ch_cnt[c*16 +: 16] !== 16'd100 || n[c] != 100) begin
                failures++;
                $display("FAIL stats ch%0d: cnt=%0d sent=%0d want 100", c, ch_cnt[c*16 +: 16], n[c]);
            end
        end
    endtask
`endif

    initial begin
        rstn = 1'b0;
        ch_valid = '0;
        ch_data = '0;
        mready = 1'b1;
        test_reset();
        test_single();
        test_fill();
        test_round_robin();
        test_reset_mid();
`ifdef MCDT_STAT_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
